// File: rtl/hw_ctrl_seq.sv
// rtl/hw_ctrl_seq.sv - beat/st0 hardwired control sequencer with console modes and halt/step
// Combinational control word from beat, st0, sw and ir; sequencing state registered on t3.
module hw_ctrl_seq #(
  parameter int OP_W    = 4,
  parameter int STEP_EN = 1
) (
  input  logic            t3,
  input  logic            clr,
  input  logic [2:0]      sw,
  input  logic [OP_W-1:0] ir,
  input  logic            c,
  input  logic            z,
  input  logic            start,
  input  logic            step,
  output logic [2:0]      w,
  output logic            st0,
  output logic            halted,
  output logic            illegal,
  output logic [26:0]     ctl
);

  typedef enum logic [1:0] {B_W1 = 2'd0, B_W2 = 2'd1, B_W3 = 2'd2} beat_t;

  localparam logic [3:0] OP_ADD = 4'b0001, OP_SUB = 4'b0010, OP_AND = 4'b0011,
                         OP_INC = 4'b0100, OP_LD  = 4'b0101, OP_ST  = 4'b0110,
                         OP_JC  = 4'b0111, OP_JZ  = 4'b1000, OP_JMP = 4'b1001,
                         OP_STP = 4'b1110;

  beat_t       beat, beat_nx;
  logic [2:0]  sw_prev;
  logic        hi_nz, step_on, st0_nx, ill_now;
  logic [3:0]  op, sel, s;
  logic        m, cin, abus, sbus, mbus, drw, memw, lar, arinc, lpc, pcinc, pcadd;
  logic        lir, ldz, ldc, selctl, f_short, f_long, stop;
  logic [26:0] raw;

  generate
    if (OP_W > 4) begin : g_hi
      assign hi_nz = |ir[OP_W-1:4];
    end else begin : g_nohi
      assign hi_nz = 1'b0;
    end
  endgenerate

  assign op      = ir[3:0];
  assign step_on = (STEP_EN != 0) && step;

  always_comb begin
    sel = 4'd0; s = 4'd0; m = 1'b0; cin = 1'b0; abus = 1'b0; sbus = 1'b0;
    mbus = 1'b0; drw = 1'b0; memw = 1'b0; lar = 1'b0; arinc = 1'b0; lpc = 1'b0;
    pcinc = 1'b0; pcadd = 1'b0; lir = 1'b0; ldz = 1'b0; ldc = 1'b0; selctl = 1'b0;
    f_short = 1'b0; f_long = 1'b0; stop = 1'b0;
    st0_nx = st0;
    ill_now = 1'b0;
    case (sw)
      3'b000: begin
        if (!st0) begin
          if (beat == B_W1) begin
            sbus = 1'b1; lpc = 1'b1; f_short = 1'b1; stop = 1'b1; st0_nx = 1'b1;
          end
        end else begin
          case (beat)
            B_W1: begin
              lir = 1'b1; pcinc = 1'b1;
            end
            B_W2: begin
              if (hi_nz) begin
                ill_now = 1'b1;
              end else begin
                case (op)
                  OP_ADD: begin s = 4'b1001; cin = 1'b1; abus = 1'b1; drw = 1'b1; ldz = 1'b1; ldc = 1'b1; end
                  OP_SUB: begin s = 4'b0110; abus = 1'b1; drw = 1'b1; ldz = 1'b1; ldc = 1'b1; end
                  OP_AND: begin m = 1'b1; s = 4'b1011; abus = 1'b1; drw = 1'b1; ldz = 1'b1; end
                  OP_INC: begin s = 4'b0000; abus = 1'b1; drw = 1'b1; ldz = 1'b1; ldc = 1'b1; end
                  OP_LD:  begin m = 1'b1; s = 4'b1010; abus = 1'b1; lar = 1'b1; f_long = 1'b1; end
                  OP_ST:  begin m = 1'b1; s = 4'b1111; abus = 1'b1; lar = 1'b1; f_long = 1'b1; end
                  OP_JC:  pcadd = c;
                  OP_JZ:  pcadd = z;
                  OP_JMP: begin m = 1'b1; s = 4'b1111; abus = 1'b1; lpc = 1'b1; end
                  OP_STP: stop = 1'b1;
                  default: ;
                endcase
              end
              if (step_on && !f_long) stop = 1'b1;
            end
            B_W3: begin
              if (!hi_nz && op == OP_LD) begin
                mbus = 1'b1; drw = 1'b1; stop = step_on;
              end else if (!hi_nz && op == OP_ST) begin
                m = 1'b1; s = 4'b1010; abus = 1'b1; memw = 1'b1; stop = step_on;
              end
            end
            default: ;
          endcase
        end
      end
      3'b001, 3'b010: begin
        if (beat == B_W1) begin
          selctl = 1'b1; f_short = 1'b1; stop = 1'b1;
          if (!st0) begin
            sbus = 1'b1; lar = 1'b1; st0_nx = 1'b1;
          end else if (sw == 3'b001) begin
            sbus = 1'b1; memw = 1'b1; arinc = 1'b1;
          end else begin
            mbus = 1'b1; arinc = 1'b1;
          end
        end
      end
      3'b011: begin
        if (beat == B_W1) begin
          sel = 4'b0001; selctl = 1'b1; stop = 1'b1;
        end else if (beat == B_W2) begin
          sel = 4'b1011; selctl = 1'b1; stop = 1'b1;
        end
      end
      3'b100: begin
        if (beat == B_W1 || beat == B_W2) begin
          sbus = 1'b1; drw = 1'b1; selctl = 1'b1; stop = 1'b1;
          if (beat == B_W1) sel = st0 ? 4'b1001 : 4'b0011;
          else begin
            sel = st0 ? 4'b1110 : 4'b0100;
            st0_nx = ~st0;
          end
        end
      end
      default: ;
    endcase
  end

  assign raw = {sel, s, m, cin, abus, sbus, mbus, drw, memw, lar, arinc, lpc,
                pcinc, pcadd, lir, ldz, ldc, selctl, f_short, f_long, stop};

  always_comb begin
    case (beat)
      B_W1:    beat_nx = f_short ? B_W1 : B_W2;
      B_W2:    beat_nx = f_long ? B_W3 : B_W1;
      default: beat_nx = B_W1;
    endcase
    // Modes 101..111 idle at W1.
    if (sw[2] && sw != 3'b100) beat_nx = B_W1;
  end

  always_comb begin
    if (clr) begin
      ctl = 27'd0;
      w   = 3'b000;
    end else if (halted) begin
      ctl = 27'd1;
      w   = 3'b000;
    end else begin
      ctl = raw;
      case (beat)
        B_W1:    w = 3'b001;
        B_W2:    w = 3'b010;
        B_W3:    w = 3'b100;
        default: w = 3'b000;
      endcase
    end
  end

  always_ff @(posedge t3 or posedge clr) begin
    if (clr) begin
      beat    <= B_W1;
      st0     <= 1'b0;
      halted  <= 1'b0;
      illegal <= 1'b0;
      sw_prev <= sw;
    end else begin
      sw_prev <= sw;
      if (sw != sw_prev) begin
        beat   <= B_W1;
        st0    <= 1'b0;
        halted <= 1'b0;
      end else if (halted) begin
        if (start) halted <= 1'b0;
      end else begin
        // The beat following a stop is latched here and runs once start arrives.
        beat <= beat_nx;
        st0  <= st0_nx;
        if (stop) halted <= 1'b1;
        if (ill_now) illegal <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hw_ctrl_seq.sv
// tb/tb_hw_ctrl_seq.sv - directed table-driven bench for hw_ctrl_seq
module tb_hw_ctrl_seq;

  logic        t3, clr, c, z, start, step;
  logic [2:0]  sw;
  logic [5:0]  ir;
  logic [2:0]  w;
  logic        st0, halted, illegal;
  logic [26:0] ctl;

  int checks = 0;
  int failures = 0;

  hw_ctrl_seq #(.OP_W(6), .STEP_EN(1)) dut (
    .t3(t3), .clr(clr), .sw(sw), .ir(ir), .c(c), .z(z), .start(start), .step(step),
    .w(w), .st0(st0), .halted(halted), .illegal(illegal), .ctl(ctl)
  );

  initial t3 = 1'b0;
  always #5 t3 = ~t3;

  localparam logic [26:0] C_STOP = 27'd1 << 0,  C_LONG = 27'd1 << 1,  C_SHORT = 27'd1 << 2,
                          C_SELCTL = 27'd1 << 3, C_LDC = 27'd1 << 4, C_LDZ = 27'd1 << 5,
                          C_LIR = 27'd1 << 6,   C_PCADD = 27'd1 << 7, C_PCINC = 27'd1 << 8,
                          C_LPC = 27'd1 << 9,   C_ARINC = 27'd1 << 10, C_LAR = 27'd1 << 11,
                          C_MEMW = 27'd1 << 12, C_DRW = 27'd1 << 13, C_MBUS = 27'd1 << 14,
                          C_SBUS = 27'd1 << 15, C_ABUS = 27'd1 << 16, C_CIN = 27'd1 << 17,
                          C_M = 27'd1 << 18;
  localparam logic [26:0] C_FETCH = C_LIR | C_PCINC;
  localparam logic [26:0] C_RW = C_SBUS | C_DRW | C_SELCTL | C_STOP;

  function automatic logic [26:0] fsel(input logic [3:0] v);
    return {v, 23'd0};
  endfunction

  function automatic logic [26:0] fs(input logic [3:0] v);
    return {4'd0, v, 19'd0};
  endfunction

  typedef struct {
    logic [2:0]  sw;
    logic [5:0]  ir;
    logic        c, z, start, step;
    logic [2:0]  w;
    logic        st0, halted, illegal;
    logic [26:0] ctl;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [2:0] s_sw, input logic [5:0] s_ir, input logic s_c,
                     input logic s_z, input logic s_start, input logic s_step,
                     input logic [2:0] e_w, input logic e_st0, input logic e_h,
                     input logic e_il, input logic [26:0] e_ctl);
    vec_t v;
    v.sw = s_sw; v.ir = s_ir; v.c = s_c; v.z = s_z; v.start = s_start; v.step = s_step;
    v.w = e_w; v.st0 = e_st0; v.halted = e_h; v.illegal = e_il; v.ctl = e_ctl;
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input logic [2:0] e_w, input logic e_st0,
                       input logic e_h, input logic e_il, input logic [26:0] e_ctl);
    checks++;
    if ({w, st0, halted, illegal, ctl} !== {e_w, e_st0, e_h, e_il, e_ctl}) begin
      failures++;
      $display("FAIL %s got w=%b st0=%b halted=%b illegal=%b ctl=%h want w=%b st0=%b halted=%b illegal=%b ctl=%h",
               nm, w, st0, halted, illegal, ctl, e_w, e_st0, e_h, e_il, e_ctl);
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    sw = v.sw; ir = v.ir; c = v.c; z = v.z; start = v.start; step = v.step;
    #1;
    check(nm, v.w, v.st0, v.halted, v.illegal, v.ctl);
    @(posedge t3);
    #1;
  endtask

  initial begin
    vec_t v;
    clr = 1'b1; sw = 3'b001; ir = '0; c = 1'b0; z = 1'b0; start = 1'b0; step = 1'b0;

    // memory write / read, register read, register write
    add(3'd1, 6'h0, 0, 0, 0, 0, 3'b001, 0, 0, 0, C_SBUS | C_LAR | C_SELCTL | C_SHORT | C_STOP);
    add(3'd1, 6'h0, 0, 0, 0, 0, 3'b000, 1, 1, 0, C_STOP);
    add(3'd1, 6'h0, 0, 0, 1, 0, 3'b000, 1, 1, 0, C_STOP);
    add(3'd1, 6'h0, 0, 0, 0, 0, 3'b001, 1, 0, 0, C_SBUS | C_MEMW | C_ARINC | C_SELCTL | C_SHORT | C_STOP);
    add(3'd1, 6'h0, 0, 0, 1, 0, 3'b000, 1, 1, 0, C_STOP);
    add(3'd2, 6'h0, 0, 0, 0, 0, 3'b001, 1, 0, 0, C_MBUS | C_ARINC | C_SELCTL | C_SHORT | C_STOP);
    add(3'd2, 6'h0, 0, 0, 0, 0, 3'b001, 0, 0, 0, C_SBUS | C_LAR | C_SELCTL | C_SHORT | C_STOP);
    add(3'd2, 6'h0, 0, 0, 0, 0, 3'b000, 1, 1, 0, C_STOP);
    add(3'd3, 6'h0, 0, 0, 0, 0, 3'b000, 1, 1, 0, C_STOP);
    add(3'd3, 6'h0, 0, 0, 0, 0, 3'b001, 0, 0, 0, fsel(4'b0001) | C_SELCTL | C_STOP);
    add(3'd3, 6'h0, 0, 0, 1, 0, 3'b000, 0, 1, 0, C_STOP);
    add(3'd3, 6'h0, 0, 0, 0, 0, 3'b010, 0, 0, 0, fsel(4'b1011) | C_SELCTL | C_STOP);
    add(3'd4, 6'h0, 0, 0, 0, 0, 3'b000, 0, 1, 0, C_STOP);
    add(3'd4, 6'h0, 0, 0, 0, 0, 3'b001, 0, 0, 0, fsel(4'b0011) | C_RW);
    add(3'd4, 6'h0, 0, 0, 1, 0, 3'b000, 0, 1, 0, C_STOP);
    add(3'd4, 6'h0, 0, 0, 0, 0, 3'b010, 0, 0, 0, fsel(4'b0100) | C_RW);
    add(3'd4, 6'h0, 0, 0, 1, 0, 3'b000, 1, 1, 0, C_STOP);
    add(3'd4, 6'h0, 0, 0, 0, 0, 3'b001, 1, 0, 0, fsel(4'b1001) | C_RW);
    add(3'd4, 6'h0, 0, 0, 1, 0, 3'b000, 1, 1, 0, C_STOP);
    add(3'd4, 6'h0, 0, 0, 0, 0, 3'b010, 1, 0, 0, fsel(4'b1110) | C_RW);
    add(3'd4, 6'h0, 0, 0, 1, 0, 3'b000, 0, 1, 0, C_STOP);
    // idle mode, then PC load with sw change overriding the stop
    add(3'd5, 6'h0, 0, 0, 0, 0, 3'b001, 0, 0, 0, 27'd0);
    add(3'd5, 6'h0, 0, 0, 0, 0, 3'b001, 0, 0, 0, 27'd0);
    add(3'd0, 6'h0, 0, 0, 0, 0, 3'b001, 0, 0, 0, C_SBUS | C_LPC | C_SHORT | C_STOP);
    add(3'd0, 6'h0, 0, 0, 0, 0, 3'b001, 0, 0, 0, C_SBUS | C_LPC | C_SHORT | C_STOP);
    add(3'd0, 6'h0, 0, 0, 1, 0, 3'b000, 1, 1, 0, C_STOP);
    // program execution
    add(3'd0, 6'h5, 0, 0, 0, 0, 3'b001, 1, 0, 0, C_FETCH);
    add(3'd0, 6'h5, 0, 0, 0, 0, 3'b010, 1, 0, 0, C_M | fs(4'b1010) | C_ABUS | C_LAR | C_LONG);
    add(3'd0, 6'h5, 0, 0, 0, 0, 3'b100, 1, 0, 0, C_MBUS | C_DRW);
    add(3'd0, 6'h7, 0, 1, 0, 0, 3'b001, 1, 0, 0, C_FETCH);
    add(3'd0, 6'h7, 0, 1, 0, 0, 3'b010, 1, 0, 0, 27'd0);
    add(3'd0, 6'h7, 1, 0, 0, 0, 3'b001, 1, 0, 0, C_FETCH);
    add(3'd0, 6'h7, 1, 0, 0, 0, 3'b010, 1, 0, 0, C_PCADD);
    add(3'd0, 6'h1, 0, 0, 0, 0, 3'b001, 1, 0, 0, C_FETCH);
    add(3'd0, 6'h1, 0, 0, 0, 0, 3'b010, 1, 0, 0, fs(4'b1001) | C_CIN | C_ABUS | C_DRW | C_LDZ | C_LDC);
    add(3'd0, 6'h6, 0, 0, 0, 0, 3'b001, 1, 0, 0, C_FETCH);
    add(3'd0, 6'h6, 0, 0, 0, 0, 3'b010, 1, 0, 0, C_M | fs(4'b1111) | C_ABUS | C_LAR | C_LONG);
    add(3'd0, 6'h6, 0, 0, 0, 0, 3'b100, 1, 0, 0, C_M | fs(4'b1010) | C_ABUS | C_MEMW);
    add(3'd0, 6'h8, 1, 1, 0, 0, 3'b001, 1, 0, 0, C_FETCH);
    add(3'd0, 6'h8, 1, 1, 0, 0, 3'b010, 1, 0, 0, C_PCADD);
    add(3'd0, 6'h3, 0, 0, 0, 1, 3'b001, 1, 0, 0, C_FETCH);
    add(3'd0, 6'h3, 0, 0, 0, 1, 3'b010, 1, 0, 0, C_M | fs(4'b1011) | C_ABUS | C_DRW | C_LDZ | C_STOP);
    add(3'd0, 6'h3, 0, 0, 1, 1, 3'b000, 1, 1, 0, C_STOP);
    add(3'd0, 6'he, 0, 0, 0, 0, 3'b001, 1, 0, 0, C_FETCH);
    add(3'd0, 6'he, 0, 0, 0, 0, 3'b010, 1, 0, 0, C_STOP);
    add(3'd0, 6'he, 0, 0, 1, 0, 3'b000, 1, 1, 0, C_STOP);
    add(3'd0, 6'h9, 0, 0, 0, 0, 3'b001, 1, 0, 0, C_FETCH);
    add(3'd0, 6'h9, 0, 0, 0, 0, 3'b010, 1, 0, 0, C_M | fs(4'b1111) | C_ABUS | C_LPC);
    add(3'd0, 6'h4, 0, 0, 0, 1, 3'b001, 1, 0, 0, C_FETCH);
    add(3'd0, 6'h4, 0, 0, 0, 1, 3'b010, 1, 0, 0, fs(4'b0000) | C_ABUS | C_DRW | C_LDZ | C_LDC | C_STOP);
    add(3'd0, 6'h4, 0, 0, 1, 0, 3'b000, 1, 1, 0, C_STOP);
    // nonzero upper opcode bits
    add(3'd0, 6'h11, 0, 0, 0, 0, 3'b001, 1, 0, 0, C_FETCH);
    add(3'd0, 6'h11, 0, 0, 0, 0, 3'b010, 1, 0, 0, 27'd0);
    add(3'd0, 6'h0, 0, 0, 0, 0, 3'b001, 1, 0, 1, C_FETCH);
    add(3'd0, 6'h0, 0, 0, 0, 0, 3'b010, 1, 0, 1, 27'd0);

    repeat (2) @(posedge t3);
    #1;
    check("reset_state", 3'b000, 1'b0, 1'b0, 1'b0, 27'd0);
    clr = 1'b0;

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("row%0d", i));

    // illegal stays set across ten SUB instructions
    for (int k = 0; k < 10; k++) begin
      v.sw = 3'd0; v.ir = 6'h2; v.c = 0; v.z = 0; v.start = 0; v.step = 0;
      v.w = 3'b001; v.st0 = 1; v.halted = 0; v.illegal = 1; v.ctl = C_FETCH;
      run_vec(v, $sformatf("sub_fetch%0d", k));
      v.w = 3'b010; v.ctl = fs(4'b0110) | C_ABUS | C_DRW | C_LDZ | C_LDC;
      run_vec(v, $sformatf("sub_exec%0d", k));
    end

    // clr asserted in the middle of ST W2
    v.sw = 3'd0; v.ir = 6'h6; v.c = 0; v.z = 0; v.start = 0; v.step = 0;
    v.w = 3'b001; v.st0 = 1; v.halted = 0; v.illegal = 1; v.ctl = C_FETCH;
    run_vec(v, "st_fetch");
    #1;
    check("st_w2", 3'b010, 1'b1, 1'b0, 1'b1, C_M | fs(4'b1111) | C_ABUS | C_LAR | C_LONG);
    #2 clr = 1'b1;
    #1;
    check("clr_mid_w2", 3'b000, 1'b0, 1'b0, 1'b0, 27'd0);
    #1 clr = 1'b0;
    #1;
    check("after_clr", 3'b001, 1'b0, 1'b0, 1'b0, C_SBUS | C_LPC | C_SHORT | C_STOP);
    @(posedge t3);
    #1;
    check("first_edge_after_clr", 3'b000, 1'b1, 1'b1, 1'b0, C_STOP);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
